// File: rtl/case_conv_sched.sv
// case_conv_sched: two-channel ASCII case converter behind a round-robin,
// string-locked scheduler with a registered valid/ready output stage.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s0_valid/ready/data/mode channel 0 byte stream (mode sampled per byte)
//   s1_valid/ready/data/mode channel 1 byte stream (mode sampled per byte)
//   m_valid/ready/data       converted byte out (registered, 1-cycle latency)
//   m_src                    channel that produced m_data
//   m_last                   final byte of a grant (NUL or LOCK_MAX-th byte)
//   busy                     scheduler holds a grant
//   stat_chg0/1              (only with CASE_CONV_STATS_EN) saturating counts
//                            of transfers whose byte was altered by conversion
//
// Optional feature macro: CASE_CONV_STATS_EN
module case_conv_sched #(
  parameter int unsigned LOCK_MAX = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s0_valid,
  output logic       s0_ready,
  input  logic [7:0] s0_data,
  input  logic [1:0] s0_mode,
  input  logic       s1_valid,
  output logic       s1_ready,
  input  logic [7:0] s1_data,
  input  logic [1:0] s1_mode,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_src,
  output logic       m_last,
  output logic       busy
`ifdef CASE_CONV_STATS_EN
  ,
  output logic [15:0] stat_chg0,
  output logic [15:0] stat_chg1
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic       rr_q, rr_d;
  logic [7:0] cnt_q, cnt_d;
  logic       m_valid_q, m_valid_d;
  logic [7:0] m_data_q, m_data_d;
  logic       m_src_q, m_src_d;
  logic       m_last_q, m_last_d;

  logic       src;
  logic       sel_valid;
  logic [7:0] sel_data;
  logic [1:0] sel_mode;
  logic       out_free;
  logic       xfer;
  logic [7:0] conv_b;
  logic [8:0] cnt_inc;
  logic       last;

  function automatic logic [7:0] conv(
    input logic [7:0] d,
    input logic [1:0] m
  );
    logic       lo;
    logic       up;
    logic [7:0] r;
    lo = (d >= 8'h61) && (d <= 8'h7A);
    up = (d >= 8'h41) && (d <= 8'h5A);
    r  = d;
    unique case (m)
      2'b01:   if (lo) r = d & 8'hDF;
      2'b10:   if (up) r = d | 8'h20;
      2'b11:   if (lo || up) r = d ^ 8'h20;
      default: r = d;
    endcase
    return r;
  endfunction

  // Datapath operand mux: the granted channel drives the converter.
  always_comb begin
    src       = (state_q == GRANT1);
    sel_valid = src ? s1_valid : s0_valid;
    sel_data  = src ? s1_data  : s0_data;
    sel_mode  = src ? s1_mode  : s0_mode;
    conv_b    = conv(sel_data, sel_mode);
    // Output register can take a byte when empty or being drained now.
    out_free  = !m_valid_q || m_ready;
    s0_ready  = (state_q == GRANT0) && out_free;
    s1_ready  = (state_q == GRANT1) && out_free;
    xfer      = (state_q != IDLE) && sel_valid && out_free;
    // 9-bit compare so LOCK_MAX=255 cannot wrap.
    cnt_inc   = {1'b0, cnt_q} + 9'd1;
    last      = (sel_data == 8'h00) || (cnt_inc == 9'(LOCK_MAX));
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (s0_valid && (!s1_valid || !rr_q)) begin
          state_d = GRANT0;
        end else if (s1_valid) begin
          state_d = GRANT1;
        end
      end
      GRANT0, GRANT1: begin
        if (xfer) begin
          cnt_d = cnt_inc[7:0];
          if (last) begin
            state_d = IDLE;
            rr_d    = !src;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_valid_d = m_valid_q && !m_ready;
    m_data_d  = m_data_q;
    m_src_d   = m_src_q;
    m_last_d  = m_last_q;
    if (xfer) begin
      m_valid_d = 1'b1;
      m_data_d  = conv_b;
      m_src_d   = src;
      m_last_d  = last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      cnt_q     <= 8'd0;
      m_valid_q <= 1'b0;
      m_data_q  <= 8'd0;
      m_src_q   <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_src_q   <= m_src_d;
      m_last_q  <= m_last_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_src   = m_src_q;
  assign m_last  = m_last_q;
  assign busy    = (state_q != IDLE);

`ifdef CASE_CONV_STATS_EN
  logic [15:0] chg0_q, chg0_d;
  logic [15:0] chg1_q, chg1_d;
  logic        changed;

  always_comb begin
    changed = xfer && (conv_b != sel_data);
    chg0_d  = chg0_q;
    chg1_d  = chg1_q;
    if (changed && !src && (chg0_q != 16'hFFFF)) chg0_d = chg0_q + 16'd1;
    if (changed && src && (chg1_q != 16'hFFFF)) chg1_d = chg1_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chg0_q <= 16'd0;
      chg1_q <= 16'd0;
    end else begin
      chg0_q <= chg0_d;
      chg1_q <= chg1_d;
    end
  end

  assign stat_chg0 = chg0_q;
  assign stat_chg1 = chg1_q;
`endif

endmodule

// File: tb/tb_case_conv_sched.sv
// tb_case_conv_sched: randomized and directed bench for case_conv_sched,
// scored against a string-level scheduling/conversion model.
module tb_case_conv_sched;

  localparam int LOCK = 4;

  logic       clk;
  logic       rst;
  logic       s0_valid, s0_ready;
  logic [7:0] s0_data;
  logic [1:0] s0_mode;
  logic       s1_valid, s1_ready;
  logic [7:0] s1_data;
  logic [1:0] s1_mode;
  logic       m_valid, m_ready;
  logic [7:0] m_data;
  logic       m_src, m_last, busy;
`ifdef CASE_CONV_STATS_EN
  logic [15:0] stat_chg0, stat_chg1;
`endif

  case_conv_sched #(.LOCK_MAX(LOCK)) dut (
    .clk      (clk),
    .rst      (rst),
    .s0_valid (s0_valid),
    .s0_ready (s0_ready),
    .s0_data  (s0_data),
    .s0_mode  (s0_mode),
    .s1_valid (s1_valid),
    .s1_ready (s1_ready),
    .s1_data  (s1_data),
    .s1_mode  (s1_mode),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_src    (m_src),
    .m_last   (m_last),
    .busy     (busy)
`ifdef CASE_CONV_STATS_EN
    ,
    .stat_chg0(stat_chg0),
    .stat_chg1(stat_chg1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Per-channel pending bytes as {mode, data}.
  logic [9:0] q0[$];
  logic [9:0] q1[$];
  // Expected output as {src, last, data}.
  logic [9:0] exp_q[$];
  int pops[$];
  int rr_m;
  int st0, st1;
  int stall_cnt;

  function automatic logic [7:0] ref_conv(input logic [7:0] d,
                                          input logic [1:0] m);
    int v;
    bit lo, up;
    v  = int'(d);
    lo = (v >= 97) && (v <= 122);
    up = (v >= 65) && (v <= 90);
    case (m)
      2'd1: if (lo) v = v - 32;
      2'd2: if (up) v = v + 32;
      2'd3: if (lo) v = v - 32; else if (up) v = v + 32;
      default: ;
    endcase
    return v[7:0];
  endfunction

  task automatic push_byte(input int ch, input logic [1:0] m,
                           input logic [7:0] d);
    if (ch == 0) q0.push_back({m, d});
    else q1.push_back({m, d});
  endtask

  task automatic push_str(input int ch, input string s,
                          input logic [1:0] m, input bit nul);
    for (int i = 0; i < s.len(); i++) push_byte(ch, m, s[i]);
    if (nul) push_byte(ch, m, 8'h00);
  endtask

  // Whole-string model: both sources stay valid while they have bytes,
  // so grants follow round-robin over NUL / LOCK-bounded chunks.
  task automatic build_expected();
    logic [9:0] c0[$];
    logic [9:0] c1[$];
    logic [9:0] b;
    logic [7:0] o;
    int n, cnt;
    bit lst;
    c0 = q0;
    c1 = q1;
    while (c0.size() > 0 || c1.size() > 0) begin
      if (c0.size() > 0 && c1.size() > 0) n = rr_m;
      else n = (c0.size() > 0) ? 0 : 1;
      cnt = 0;
      lst = 0;
      while (!lst && ((n == 0) ? c0.size() : c1.size()) > 0) begin
        b = (n == 0) ? c0.pop_front() : c1.pop_front();
        o = ref_conv(b[7:0], b[9:8]);
        cnt++;
        lst = (b[7:0] == 8'h00) || (cnt == LOCK);
        if (o != b[7:0]) begin
          if (n == 0) st0++;
          else st1++;
        end
        exp_q.push_back({n[0], lst, o});
      end
      if (lst) rr_m = 1 - n;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; s0_valid = 0; s1_valid = 0; m_ready = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    q0.delete(); q1.delete(); exp_q.delete();
    rr_m = 0; st0 = 0; st1 = 0;
  endtask

  // rdy_pct: 100 = always ready, -1 = stall cycles 4..8, else random %.
  task automatic run_stream(input string name, input int rdy_pct,
                            input int budget);
    int c, idx;
    bit a0, a1, pop, hold;
    logic [9:0] snap, e;
    c = 0; idx = 0; hold = 0; stall_cnt = 0;
    pops.delete();
    while ((q0.size() > 0 || q1.size() > 0 || exp_q.size() > 0)
           && c < budget) begin
      @(negedge clk);
      s0_valid = (q0.size() > 0);
      s0_data  = s0_valid ? q0[0][7:0] : 8'($urandom);
      s0_mode  = s0_valid ? q0[0][9:8] : 2'($urandom);
      s1_valid = (q1.size() > 0);
      s1_data  = s1_valid ? q1[0][7:0] : 8'($urandom);
      s1_mode  = s1_valid ? q1[0][9:8] : 2'($urandom);
      if (rdy_pct == 100) m_ready = 1;
      else if (rdy_pct < 0) m_ready = (c < 4 || c > 8);
      else m_ready = ($urandom_range(99) < rdy_pct);
      #1;
      a0  = s0_valid && s0_ready;
      a1  = s1_valid && s1_ready;
      pop = m_valid && m_ready;
      if (hold) begin
        checks++;
        if ({m_src, m_last, m_data} !== snap || m_valid !== 1'b1)
          $display("FAIL %s hold: got v=%b %h expected v=1 %h",
                   name, m_valid, {m_src, m_last, m_data}, snap);
        else passes++;
      end
      if (m_valid && !m_ready) begin
        stall_cnt++;
        checks++;
        if (s0_ready !== 1'b0 || s1_ready !== 1'b0)
          $display("FAIL %s stall ready: got %b%b expected 00",
                   name, s0_ready, s1_ready);
        else passes++;
        hold = 1;
        snap = {m_src, m_last, m_data};
      end else hold = 0;
      if (pop) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL %s extra byte: got %h expected none",
                   name, m_data);
        end else begin
          e = exp_q.pop_front();
          if ({m_src, m_last, m_data} !== e)
            $display("FAIL %s out[%0d]: got src=%0d last=%0d data=%h expected src=%0d last=%0d data=%h",
                     name, idx, m_src, m_last, m_data, e[9], e[8], e[7:0]);
          else passes++;
        end
        pops.push_back(c);
        idx++;
      end
      @(posedge clk);
      if (a0) void'(q0.pop_front());
      if (a1) void'(q1.pop_front());
      c++;
    end
    checks++;
    if (c >= budget)
      $display("FAIL %s timeout: got %0d bytes pending expected 0",
               name, exp_q.size());
    else passes++;
    @(negedge clk);
    s0_valid = 0; s1_valid = 0; m_ready = 1;
    exp_q.delete(); q0.delete(); q1.delete();
  endtask

`ifdef CASE_CONV_STATS_EN
  task automatic check_stats(input string name);
    checks++;
    if (stat_chg0 !== 16'(st0) || stat_chg1 !== 16'(st1))
      $display("FAIL %s stats: got %0d/%0d expected %0d/%0d",
               name, stat_chg0, stat_chg1, st0, st1);
    else passes++;
  endtask
`endif

  task automatic test_reset();
    do_reset();
    checks++;
    if ({m_valid, m_data, m_src, m_last, busy, s0_ready, s1_ready}
        !== 14'd0)
      $display("FAIL reset: got v=%b d=%h s=%b l=%b b=%b r=%b%b expected all 0",
               m_valid, m_data, m_src, m_last, busy, s0_ready, s1_ready);
    else passes++;
`ifdef CASE_CONV_STATS_EN
    check_stats("reset");
`endif
  endtask

  task automatic test_upper_string();
    push_str(0, "ab1", 2'd1, 1);
    build_expected();
    run_stream("upper", 100, 200);
    checks++;
    if (pops.size() != 4 || pops[3] - pops[0] != 3)
      $display("FAIL upper spacing: got n=%0d expected 4 consecutive",
               pops.size());
    else passes++;
    checks++;
    if (busy !== 1'b0) $display("FAIL upper busy: got %b expected 0", busy);
    else passes++;
  endtask

  task automatic test_contention();
    do_reset();
    push_str(0, "x", 2'd1, 1);
    push_str(1, "x", 2'd1, 1);
    build_expected();
    run_stream("contend", 100, 200);
    checks++;
    if (pops.size() != 4 || pops[2] - pops[1] != 2)
      $display("FAIL contend bubble: got gap=%0d expected 2",
               pops.size() == 4 ? pops[2] - pops[1] : -1);
    else passes++;
    push_str(0, "y", 2'd1, 1);
    push_str(1, "z", 2'd1, 1);
    build_expected();
    run_stream("contend2", 100, 200);
  endtask

  task automatic test_lock_limit();
    push_str(1, "ABCDEF", 2'd2, 1);
    build_expected();
    run_stream("lock", 100, 200);
    checks++;
    if (pops.size() != 7 || pops[4] - pops[3] != 2)
      $display("FAIL lock bubble: got n=%0d expected 7 with gap 2",
               pops.size());
    else passes++;
  endtask

  task automatic test_stall();
    push_str(0, "HeLLo wOrld", 2'd2, 1);
    build_expected();
    run_stream("stall", -1, 300);
    checks++;
    if (stall_cnt < 5)
      $display("FAIL stall count: got %0d expected >=5", stall_cnt);
    else passes++;
  endtask

  task automatic test_toggle();
    push_str(0, "aZ{", 2'd3, 0);
    push_byte(0, 2'd3, 8'hE1);
    push_byte(0, 2'd3, 8'h00);
    build_expected();
    run_stream("toggle", 100, 200);
  endtask

  task automatic test_random();
    int len;
    logic [7:0] d;
    for (int r = 0; r < 12; r++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if ($urandom_range(3) != 0) begin
          len = $urandom_range(9);
          for (int i = 0; i < len; i++) begin
            case ($urandom_range(3))
              0: d = 8'h61 + 8'($urandom_range(25));
              1: d = 8'h41 + 8'($urandom_range(25));
              2: d = 8'($urandom_range(127, 1));
              default: d = 8'($urandom_range(255, 128));
            endcase
            push_byte(ch, 2'($urandom), d);
          end
          push_byte(ch, 2'($urandom), 8'h00);
        end
      end
      build_expected();
      run_stream("random", (r % 2) ? 40 : 85, 600);
    end
`ifdef CASE_CONV_STATS_EN
    check_stats("random");
`endif
  endtask

  task automatic test_reset_midop();
    push_str(0, "k", 2'd0, 1);
    build_expected();
    run_stream("pre_rst", 100, 100);
    @(negedge clk);
    s0_valid = 1; s0_data = 8'h61; s0_mode = 2'd1; m_ready = 0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || busy !== 1'b1 || m_src !== 1'b0)
      $display("FAIL midop setup: got v=%b b=%b s=%b expected 1 1 0",
               m_valid, busy, m_src);
    else passes++;
    rst = 1;
    @(negedge clk);
    rst = 0; s0_valid = 0; m_ready = 1;
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL midop reset: got v=%b b=%b expected 0 0",
               m_valid, busy);
    else passes++;
    q0.delete(); q1.delete(); exp_q.delete();
    rr_m = 0; st0 = 0; st1 = 0;
`ifdef CASE_CONV_STATS_EN
    check_stats("midop");
`endif
    push_str(0, "p", 2'd0, 1);
    push_str(1, "q", 2'd0, 1);
    build_expected();
    run_stream("post_rst", 100, 200);
  endtask

  initial begin
    rst = 1; m_ready = 1;
    s0_valid = 0; s0_data = 0; s0_mode = 0;
    s1_valid = 0; s1_data = 0; s1_mode = 0;
    test_reset();
    test_upper_string();
    test_contention();
    test_lock_limit();
    test_stall();
    test_toggle();
    test_random();
    test_reset_midop();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/case_conv_sched.md
Name: case_conv_sched

Overview:
- Shares one ASCII case-conversion datapath between two byte-stream requesters.
- Each requester sends a NUL-terminated string; the scheduler grants one channel at a time, holds the grant until the string ends or a burst limit is reached, then hands over round-robin.
- Converted bytes leave through a single registered valid/ready output, tagged with the source channel.

Parameters:
- LOCK_MAX, 64: maximum bytes per grant before forced release; legal range 1..255.

Ports:
- clk      input   1  system clock; all state updates on the rising edge
- rst      input   1  synchronous, active-high reset
- s0_valid input   1  channel 0 byte valid
- s0_ready output  1  channel 0 byte accepted this cycle when s0_valid is also high
- s0_data  input   8  channel 0 byte
- s0_mode  input   2  channel 0 conversion mode, sampled with each byte
- s1_valid input   1  channel 1 byte valid
- s1_ready output  1  channel 1 byte accepted this cycle when s1_valid is also high
- s1_data  input   8  channel 1 byte
- s1_mode  input   2  channel 1 conversion mode, sampled with each byte
- m_valid  output  1  output byte valid
- m_ready  input   1  downstream accepts the output byte
- m_data   output  8  converted byte
- m_src    output  1  source channel of m_data
- m_last   output  1  high with the final byte of a grant (NUL byte or LOCK_MAX-th byte)
- busy     output  1  high when the state is not IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE; rr=0, meaning channel 0 has priority; cnt=0; m_valid=0; m_data=0; m_src=0; m_last=0; busy=0.
- Conversion, combinational on the accepted byte d:
  - mode 00 passthrough: d unchanged.
  - mode 01 upper: 0x61..0x7A -> d & 0xDF; all other bytes unchanged.
  - mode 10 lower: 0x41..0x5A -> d | 0x20; all other bytes unchanged.
  - mode 11 toggle: d ^ 0x20 for bytes in either letter range; all other bytes unchanged.
  - Bytes >= 0x80 and non-letters always pass unchanged in every mode.
- FSM states: IDLE, GRANT0, GRANT1.
- IDLE:
  - Both sN_ready are 0.
  - If only sK_valid is high -> GRANTK.
  - If both are high -> GRANT(rr).
  - If neither is high -> stay in IDLE.
  - cnt is cleared on leaving IDLE.
- GRANTn:
  - sn_ready = !m_valid | m_ready. The other channel's ready is 0.
  - A transfer (sn_valid & sn_ready) loads the output register on the same edge: m_data=conv(sn_data, sn_mode), m_src=n, m_valid=1, and cnt increments.
  - m_last=1 when the transferred byte is 0x00 or cnt+1==LOCK_MAX. On that edge: state -> IDLE and rr -> !n.
  - A grant ends only on a transfer; there is no timeout while the source stalls.
- Output register:
  - Latency is 1 cycle from transfer to m_valid.
  - m_valid, m_data, m_src and m_last are held stable while m_valid & !m_ready.
  - m_valid clears on m_ready when no new transfer happens that cycle.
  - A simultaneous pop and push gives full throughput (1 byte/cycle within a grant).
- Handover: the cycle spent in IDLE costs one bubble between grants. The last byte of the previous grant may still sit in the output register during that IDLE cycle.
- NUL handling: a NUL with LOCK_MAX=1 produces a single m_last; it is not doubled.
- Reset during operation: any in-flight output byte is discarded (m_valid=0 on the next cycle) and the grant is dropped. Sources must re-send.
- Value stability: s*_data and s*_mode may change freely while not accepted; only the value at the transfer edge matters.

Optional Feature:
- Macro: CASE_CONV_STATS_EN.
- Defined: adds output ports stat_chg0 and stat_chg1, 16 bits each, with reset value 0.
  - stat_chgN increments on each channel-N transfer whose converted byte differs from the input byte.
  - Both counters saturate at 0xFFFF.
- Undefined: these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then s0 sends "ab1\0" with mode 01 and m_ready=1 held -> m_data 0x41, 0x42, 0x31, 0x00 on consecutive cycles; m_src=0; m_last only on the 0x00 byte; busy back to 0 after the NUL.
- s0 and s1 both valid from reset, each sending "x\0" with mode 01 -> channel 0 string first ("X\0"), one IDLE bubble, then channel 1 string; the next contention grants channel 0 again only after channel 1 has been served.
- LOCK_MAX=4, s1 streams 6 non-NUL bytes with mode 10 while s0 is idle -> m_last on the 4th byte; channel 1 regains the grant after the IDLE cycle; remaining bytes follow.
- Downstream stall: m_ready=0 for 5 cycles mid-string -> m_data is held stable, sN_ready=0, and no byte is lost or duplicated after release.
- Mode 11 on "aZ{\xE1" -> output 0x41, 0x7A, 0x7B, 0xE1.
- rst asserted for one cycle while m_valid=1 in GRANT0 -> next cycle m_valid=0, busy=0, rr=0; with CASE_CONV_STATS_EN defined, stat_chg0 and stat_chg1 read 0.
